// File: rtl/mips_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control_if
//   Bundle between the multicycle MIPS control unit and its datapath.
//   The control unit sits on the master side. It receives the IR opcode and
//   drives every datapath mux select and write enable, plus the Beq/Bne
//   strobes and the State debug bus. The datapath sits on the slave side.
//
//   Signals:
//     Opcode   IR[31:26], driven by the datapath
//     IorD     memory address select (PC / ALUOut)
//     MemWrite memory write enable
//     IRWrite  instruction register load
//     RegDst   register file destination select (rt / rd)
//     MemtoReg register file write data select (ALUOut / MDR)
//     RegWrite register file write enable
//     ALUSrcA  ALU A select (PC / reg A)
//     ALUSrcB  ALU B select (regB / 4 / ext imm / imm<<2)
//     ALUOp    ALU operation class (add / sub / funct / or)
//     PCSrc    next-PC select (ALU result / ALUOut / jump target)
//     PCWrite  unconditional PC write
//     Beq, Bne branch compare strobes to the branch-condition logic
//     State    current FSM state (debug/verification)
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       Beq;
  logic       Bne;
  logic [3:0] State;

  modport master (
    input  Opcode,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Beq, Bne, State
  );

  modport slave (
    output Opcode,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Beq, Bne, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//   Moore FSM control unit for the multicycle MIPS core. Sequences
//   fetch / decode / execute / memory / writeback from the IR opcode and
//   drives every datapath select and write enable. The datapath forms its
//   PC enable as PCWrite | Branch. Branch comes back from the branch-condition
//   logic, which is qualified by the Beq/Bne strobes driven here.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset. Forces FETCH.
//     bus    control bundle (master side): Opcode in; all controls and
//            the State debug bus out
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter logic [5:0] LW_OP   = 6'h23,
  parameter logic [5:0] SW_OP   = 6'h2B,
  parameter logic [5:0] RT_OP   = 6'h00,
  parameter logic [5:0] BEQ_OP  = 6'h04,
  parameter logic [5:0] BNE_OP  = 6'h05,
  parameter logic [5:0] ADDI_OP = 6'h08,
  parameter logic [5:0] ORI_OP  = 6'h0D,
  parameter logic [5:0] J_OP    = 6'h02
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_control_if.master     bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BEQ_S   = 4'd8,
    BNE_S   = 4'd9,
    ADDI_EX = 4'd10,
    ORI_EX  = 4'd11,
    IMMWB   = 4'd12,
    JUMP    = 4'd13,
    ILL14   = 4'd14,
    ILL15   = 4'd15
  } state_t;

  // Instruction class recovered from the opcode. Unknown opcodes fall into
  // INS_NOP and retire straight back to FETCH.
  typedef enum logic [2:0] {
    INS_NOP,
    INS_MEM,
    INS_RTYPE,
    INS_BEQ,
    INS_BNE,
    INS_ADDI,
    INS_ORI,
    INS_JUMP
  } ins_class_t;

  state_t     state;
  state_t     next_state;
  ins_class_t ins_class;
  logic       is_store;

  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       beq;
  logic       bne;

  // Classify the opcode. Only DECODE and MEMADR act on the result.
  // In all other states the opcode is ignored.
  always_comb begin
    ins_class = INS_NOP;
    unique case (bus.Opcode)
      LW_OP, SW_OP: ins_class = INS_MEM;
      RT_OP:        ins_class = INS_RTYPE;
      BEQ_OP:       ins_class = INS_BEQ;
      BNE_OP:       ins_class = INS_BNE;
      ADDI_OP:      ins_class = INS_ADDI;
      ORI_OP:       ins_class = INS_ORI;
      J_OP:         ins_class = INS_JUMP;
      default:      ins_class = INS_NOP;
    endcase
  end

  // MEMADR looks at the opcode again. Only an exact store opcode selects
  // the write path. Anything else there is handled as a load.
  assign is_store = (bus.Opcode == SW_OP);

  // State register. Reset drops the FSM into FETCH without waiting for a
  // clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The default return to FETCH covers every
  // single-exit state and the two unused encodings.
  always_comb begin
    next_state = FETCH;
    unique case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        unique case (ins_class)
          INS_MEM:   next_state = MEMADR;
          INS_RTYPE: next_state = EXEC;
          INS_BEQ:   next_state = BEQ_S;
          INS_BNE:   next_state = BNE_S;
          INS_ADDI:  next_state = ADDI_EX;
          INS_ORI:   next_state = ORI_EX;
          INS_JUMP:  next_state = JUMP;
          default:   next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = is_store ? MEMWR : MEMRD;
      MEMRD:   next_state = MEMWB;
      EXEC:    next_state = ALUWB;
      ADDI_EX: next_state = IMMWB;
      ORI_EX:  next_state = IMMWB;
      default: next_state = FETCH;
    endcase
  end

  // Moore outputs. Each is a function of the state register only.
  // Everything defaults to 0, so each state lists only the signals it
  // asserts.
  // The two branch states drive the subtract compare and select ALUOut
  // (the target computed in DECODE) as the next PC. The PC load itself
  // comes from Branch, so PCWrite stays low there.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    unique case (state)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      DECODE: begin
        alu_src_b = 2'b11;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQ_S: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        beq       = 1'b1;
      end
      BNE_S: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        bne       = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ORI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      IMMWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.IorD     = iord;
  assign bus.MemWrite = mem_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.PCSrc    = pc_src;
  assign bus.PCWrite  = pc_write;
  assign bus.Beq      = beq;
  assign bus.Bne      = bne;
  assign bus.State    = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//   Self-checking bench for the multicycle MIPS control unit. Each
//   instruction is expanded into the state sequence it should walk through.
//   Every cycle is compared against the control word listed for that state.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

  logic clk;
  logic reset;
  int   check_count;
  int   fail_count;

  mips_multicycle_control_if ctrl_bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ctrl_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCWrite;
    logic       Beq;
    logic       Bne;
  } ctrl_t;

  function automatic ctrl_t observed();
    ctrl_t c;
    c.IorD     = ctrl_bus.IorD;
    c.MemWrite = ctrl_bus.MemWrite;
    c.IRWrite  = ctrl_bus.IRWrite;
    c.RegDst   = ctrl_bus.RegDst;
    c.MemtoReg = ctrl_bus.MemtoReg;
    c.RegWrite = ctrl_bus.RegWrite;
    c.ALUSrcA  = ctrl_bus.ALUSrcA;
    c.ALUSrcB  = ctrl_bus.ALUSrcB;
    c.ALUOp    = ctrl_bus.ALUOp;
    c.PCSrc    = ctrl_bus.PCSrc;
    c.PCWrite  = ctrl_bus.PCWrite;
    c.Beq      = ctrl_bus.Beq;
    c.Bne      = ctrl_bus.Bne;
    return c;
  endfunction

  // Control word each state should present. Signals that are not listed
  // for a state stay 0.
  function automatic ctrl_t expected_word(int s);
    ctrl_t c;
    c = '0;
    if (s == 0) begin c.IRWrite = 1; c.PCWrite = 1; c.ALUSrcB = 2'b01; end
    if (s == 1) c.ALUSrcB = 2'b11;
    if (s == 2 || s == 10 || s == 11) begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
    if (s == 11) c.ALUOp = 2'b11;
    if (s == 3 || s == 5) c.IorD = 1;
    if (s == 5) c.MemWrite = 1;
    if (s == 4) c.MemtoReg = 1;
    if (s == 4 || s == 7 || s == 12) c.RegWrite = 1;
    if (s == 7) c.RegDst = 1;
    if (s == 6) begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
    if (s == 8 || s == 9) begin c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCSrc = 2'b01; end
    if (s == 8) c.Beq = 1;
    if (s == 9) c.Bne = 1;
    if (s == 13) begin c.PCSrc = 2'b10; c.PCWrite = 1; end
    return c;
  endfunction

  // Expected state walk for one instruction. decode_op is the opcode
  // presented through DECODE. memadr_op is the opcode seen in MEMADR.
  function automatic void build_sequence(input logic [5:0] decode_op,
                                         input logic [5:0] memadr_op,
                                         output int seq[$]);
    seq = {0, 1};
    case (decode_op)
      6'h23, 6'h2B: begin
        seq.push_back(2);
        if (memadr_op == 6'h2B) seq.push_back(5);
        else begin seq.push_back(3); seq.push_back(4); end
      end
      6'h00:   begin seq.push_back(6);  seq.push_back(7);  end
      6'h04:   seq.push_back(8);
      6'h05:   seq.push_back(9);
      6'h08:   begin seq.push_back(10); seq.push_back(12); end
      6'h0D:   begin seq.push_back(11); seq.push_back(12); end
      6'h02:   seq.push_back(13);
      default: ;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction. The bench must be at FETCH, 1 time unit after
  // the edge. It returns at the following FETCH.
  task automatic applyStimulus(input logic [5:0] decode_op,
                               input logic [5:0] memadr_op);
    int seq[$];
    int cycles;
    build_sequence(decode_op, memadr_op, seq);
    ctrl_bus.Opcode = decode_op;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == 2) ctrl_bus.Opcode = memadr_op;
      checkOutput($sformatf("state[op=%02h,i=%0d]", decode_op, i),
                  32'(ctrl_bus.State), 32'(seq[i]));
      checkOutput($sformatf("ctrl[op=%02h,s=%0d]", decode_op, seq[i]),
                  32'(observed()), 32'(expected_word(seq[i])));
      checkOutput("beq_bne_excl", 32'(ctrl_bus.Beq & ctrl_bus.Bne), 32'd0);
      checkOutput("branch_pcwrite_excl",
                  32'((ctrl_bus.Beq | ctrl_bus.Bne) & ctrl_bus.PCWrite), 32'd0);
      @(posedge clk); #1;
    end
    cycles = seq.size();
    checkOutput($sformatf("retire[op=%02h,cpi=%0d]", decode_op, cycles),
                32'(ctrl_bus.State), 32'd0);
  endtask

  logic [5:0] legal_ops [8];
  logic [5:0] op_a;
  logic [5:0] op_b;

  initial begin
    check_count = 0;
    fail_count  = 0;
    legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};

    // Reset state
    reset = 1'b0;
    ctrl_bus.Opcode = 6'h3F;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 32'(ctrl_bus.State), 32'd0);
    checkOutput("reset_ctrl", 32'(observed()), 32'(expected_word(0)));

    // The first edge after release moves the FSM to DECODE.
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_decode", 32'(ctrl_bus.State), 32'd1);
    @(posedge clk); #1;
    checkOutput("nop_to_fetch", 32'(ctrl_bus.State), 32'd0);

    // Directed walks
    applyStimulus(6'h23, 6'h23);
    applyStimulus(6'h2B, 6'h2B);
    applyStimulus(6'h04, 6'h04);
    applyStimulus(6'h05, 6'h05);
    applyStimulus(6'h00, 6'h00);
    applyStimulus(6'h0D, 6'h0D);
    applyStimulus(6'h3F, 6'h3F);
    applyStimulus(6'h02, 6'h02);
    applyStimulus(6'h08, 6'h08);
    applyStimulus(6'h2B, 6'h11);
    applyStimulus(6'h23, 6'h2B);

    // Reset taken in the middle of MEMRD, between clock edges
    ctrl_bus.Opcode = 6'h23;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_memrd", 32'(ctrl_bus.State), 32'd3);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_state", 32'(ctrl_bus.State), 32'd0);
    checkOutput("async_reset_irwrite", 32'(ctrl_bus.IRWrite), 32'd1);
    checkOutput("async_reset_memwrite", 32'(ctrl_bus.MemWrite), 32'd0);
    checkOutput("async_reset_ctrl", 32'(observed()), 32'(expected_word(0)));
    @(posedge clk); #1;
    checkOutput("held_reset_state", 32'(ctrl_bus.State), 32'd0);
    @(negedge clk) reset = 1'b1;
    ctrl_bus.Opcode = 6'h3F;
    @(posedge clk); #1;
    checkOutput("rerelease_decode", 32'(ctrl_bus.State), 32'd1);
    @(posedge clk); #1;

    // Random instruction mix. Some load/store cases change the opcode
    // in MEMADR.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) op_a = legal_ops[$urandom_range(0, 7)];
      else op_a = 6'($urandom);
      case ($urandom_range(0, 3))
        0:       op_b = 6'($urandom);
        1:       op_b = 6'h2B;
        2:       op_b = 6'h23;
        default: op_b = op_a;
      endcase
      applyStimulus(op_a, op_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
